// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Round sequencer for the AES round/key-expansion datapath. It accepts an
//   operation on start and picks the round count from key_len
//   (00 -> NR_128, 01 -> NR_192, 10 -> NR_256, 11 -> NR_128). It steps one
//   round per en and produces the matching Rcon byte. It reports completion
//   with a one-cycle done pulse. abort drops back to idle without done.
//
// Ports
//   clk          in   1      clock, rising edge
//   arst         in   1      synchronous active-high reset
//   start        in   1      begin operation (sampled only in IDLE)
//   key_len      in   2      key size select, latched with accepted start
//   en           in   1      advance one round (ignored in IDLE)
//   abort        in   1      terminate current operation, no done
//   busy         out  1      operation in progress
//   done         out  1      single-cycle completion pulse
//   round        out  CNT_W  current round number, 0 when idle
//   first_round  out  1      busy && round == 1
//   last_round   out  1      busy && round == nr
//   rcon         out  8      Rcon byte for the current round
module aes_round_sequencer #(
    parameter int CNT_W  = 4,
    parameter int NR_128 = 10,
    parameter int NR_192 = 12,
    parameter int NR_256 = 14
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             en,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] round,
    output logic             first_round,
    output logic             last_round,
    output logic [7:0]       rcon
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [CNT_W-1:0] nr_q, nr_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             done_q, done_d;

    // GF(2^8) multiply by x, reduced modulo the AES polynomial (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Round count for a key size. The unused code 11 falls back to AES-128.
    function automatic logic [CNT_W-1:0] nr_sel(input logic [1:0] kl);
        case (kl)
            2'b01:   nr_sel = CNT_W'(NR_192);
            2'b10:   nr_sel = CNT_W'(NR_256);
            default: nr_sel = CNT_W'(NR_128);
        endcase
    endfunction

    // State and per-operation registers
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= IDLE;
            round_q <= '0;
            nr_q    <= CNT_W'(NR_128);
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // done is high during this state's first cycle, and start is
                // still honoured then. That gives zero-gap back-to-back operations.
                round_d = '0;
                rcon_d  = 8'h01;
                if (start) begin
                    state_d = RUN;
                    round_d = CNT_W'(1);
                    nr_d    = nr_sel(key_len);
                end
            end
            RUN: begin
                if (abort) begin
                    // abort wins over en, even on the final round.
                    state_d = IDLE;
                    round_d = '0;
                    rcon_d  = 8'h01;
                end else if (en) begin
                    if (round_q == nr_q) begin
                        state_d = IDLE;
                        round_d = '0;
                        rcon_d  = 8'h01;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + CNT_W'(1);
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
                rcon_d  = 8'h01;
            end
        endcase
    end

    // Outputs: decoded from registered state only, no input-to-output paths
    always_comb begin
        busy        = (state_q == RUN);
        first_round = (state_q == RUN) && (round_q == CNT_W'(1));
        last_round  = (state_q == RUN) && (round_q == nr_q);
        done        = done_q;
        round       = round_q;
        rcon        = rcon_q;
    end

endmodule
